// File: rtl/itrx_aib_phy_rx_word_align.sv
// RX word aligner: packs DDR bit pairs from the bump capture buffer into
// WORD_W-bit words, hunts a bit-granular offset against a fixed marker field,
// and presents aligned words to the adapter RX datapath once locked.
//
// Output handshake: rx_word_vld is a push-only strobe with no ready. Each
// 1-cycle pulse carries one aligned word on rx_word; rx_mrk_err marks a locked
// word whose marker failed. The word that causes the unlock raises rx_mrk_err
// alone: rx_lock is already low in that cycle, so no word is delivered with it.
module itrx_aib_phy_rx_word_align #(
  parameter int                WORD_W     = 20,
  parameter logic [WORD_W-1:0] MRK_MSK    = 20'hC0000,
  parameter logic [WORD_W-1:0] MRK_VAL    = 20'h80000,
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 3,
  localparam int               OFS_W      = $clog2(WORD_W)
) (
  input  logic              inclk,
  input  logic              rxd_irstb,
  input  logic              rx_align_en,
  input  logic              ubump_rx_0ql,
  input  logic              ubump_rx_1q,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_word_vld,
  output logic              rx_lock,
  output logic              rx_mrk_err,
  output logic [OFS_W-1:0]  rx_offset
);

  localparam int PAIRS = WORD_W / 2;
  localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Two words of history so any offset 0..WORD_W-1 can be read whole.
  logic [2*WORD_W-1:0] sr;
  logic [PC_W-1:0]     pc;
  logic                ws;
  logic [WORD_W-1:0]   cw;
  logic                match;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [3:0]          mcnt;
  logic [3:0]          mcnt_nxt;
  logic [3:0]          mcnt_inc;
  logic [3:0]          xcnt;
  logic [3:0]          xcnt_nxt;
  logic [3:0]          xcnt_inc;
  logic [OFS_W-1:0]    ofs_nxt;
  logic [OFS_W-1:0]    ofs_inc;
  logic [WORD_W-1:0]   word_nxt;
  logic                vld_nxt;
  logic                err_nxt;

  assign ws       = (pc == PC_W'(PAIRS - 1));
  assign cw       = sr[rx_offset +: WORD_W];
  assign match    = ((cw & MRK_MSK) == MRK_VAL);
  assign mcnt_inc = mcnt + 4'd1;
  assign xcnt_inc = xcnt + 4'd1;
  assign ofs_inc  = (rx_offset == OFS_W'(WORD_W - 1)) ? '0 : rx_offset + OFS_W'(1);
  assign rx_lock  = (state == ST_LOCKED);

  // Shift in one DDR pair per clock (newest at the MSB end) and count pairs per word.
  always_ff @(posedge inclk or negedge rxd_irstb) begin
    if (!rxd_irstb) begin
      sr <= '0;
      pc <= '0;
    end else begin
      sr <= {ubump_rx_1q, ubump_rx_0ql, sr[2*WORD_W-1:2]};
      pc <= ws ? '0 : pc + PC_W'(1);
    end
  end

  // Alignment decisions, taken once per word strobe; disable forces a clean HUNT.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    xcnt_nxt  = xcnt;
    ofs_nxt   = rx_offset;
    word_nxt  = rx_word;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (!rx_align_en) begin
      state_nxt = ST_HUNT;
      mcnt_nxt  = '0;
      xcnt_nxt  = '0;
      ofs_nxt   = '0;
    end else if (ws) begin
      case (state)
        ST_HUNT: begin
          if (match) begin
            if (LOCK_CNT == 1) begin
              state_nxt = ST_LOCKED;
              mcnt_nxt  = '0;
              xcnt_nxt  = '0;
              word_nxt  = cw;
              vld_nxt   = 1'b1;
            end else begin
              state_nxt = ST_VERIFY;
              mcnt_nxt  = 4'd1;
            end
          end else begin
            ofs_nxt = ofs_inc;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            mcnt_nxt = mcnt_inc;
            if (mcnt_inc == 4'(LOCK_CNT)) begin
              state_nxt = ST_LOCKED;
              mcnt_nxt  = '0;
              xcnt_nxt  = '0;
              word_nxt  = cw;
              vld_nxt   = 1'b1;
            end
          end else begin
            state_nxt = ST_HUNT;
            mcnt_nxt  = '0;
            ofs_nxt   = ofs_inc;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            xcnt_nxt = '0;
            word_nxt = cw;
            vld_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
            if (xcnt_inc == 4'(UNLOCK_CNT)) begin
              state_nxt = ST_HUNT;
              xcnt_nxt  = '0;
              mcnt_nxt  = '0;
              ofs_nxt   = ofs_inc;
            end else begin
              xcnt_nxt = xcnt_inc;
              word_nxt = cw;
              vld_nxt  = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          mcnt_nxt  = '0;
          xcnt_nxt  = '0;
        end
      endcase
    end
    // The word output only carries data while locked.
    if (state_nxt != ST_LOCKED) begin
      word_nxt = '0;
    end
  end

  // Register FSM, counters, offset and the word outputs.
  always_ff @(posedge inclk or negedge rxd_irstb) begin
    if (!rxd_irstb) begin
      state       <= ST_HUNT;
      mcnt        <= '0;
      xcnt        <= '0;
      rx_offset   <= '0;
      rx_word     <= '0;
      rx_word_vld <= 1'b0;
      rx_mrk_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      mcnt        <= mcnt_nxt;
      xcnt        <= xcnt_nxt;
      rx_offset   <= ofs_nxt;
      rx_word     <= word_nxt;
      rx_word_vld <= vld_nxt;
      rx_mrk_err  <= err_nxt;
    end
  end

endmodule
